// File: rtl/seq_add_sub_defs.sv
// Shared definitions for the digit-serial adder/subtractor: state encoding and sizing helper.
package seq_add_sub_defs;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/add_digit.sv
// DIGIT-bit ripple-carry adder built from full-adder cells; exposes the carry into the MSB
// so the caller can derive signed overflow.
module add_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle over WIDTH/DIGIT cycles,
// with registered result and flags and a one-cycle done pulse.
module seq_add_sub
    import seq_add_sub_defs::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("seq_add_sub: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_msb_in;
    logic [WIDTH-1:0] res_next;
    logic             last;
    int unsigned      base;

    always_comb begin
        base     = int'(cnt_q) * DIGIT;
        dig_a    = a_q[base +: DIGIT];
        dig_b    = b_q[base +: DIGIT];
        res_next = result;
        res_next[base +: DIGIT] = dig_sum;
        last     = (cnt_q == CW'(N - 1));
    end

    add_digit #(
        .DIGIT (DIGIT)
    ) u_add_digit (
        .a        (dig_a),
        .b        (dig_b),
        .cin      (carry_q),
        .sum      (dig_sum),
        .cout     (dig_cout),
        .c_msb_in (dig_msb_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1, the +1 entering as the initial carry.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    result  <= res_next;
                    carry_q <= dig_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= StDone;
                        cout    <= dig_cout;
                        ovf     <= dig_msb_in ^ dig_cout;
                        zero    <= (res_next == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed and random checks of seq_add_sub at WIDTH=8 (DIGIT 4/1/8) and WIDTH=32 (DIGIT 4).
module tb_seq_add_sub;
    import seq_add_sub_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8 [3];
    logic       sub8   [3];
    logic [7:0] a8     [3];
    logic [7:0] b8     [3];
    logic [7:0] res8   [3];
    logic       busy8  [3];
    logic       done8  [3];
    logic       cout8  [3];
    logic       ovf8   [3];
    logic       zero8  [3];

    logic        rst32, start32, sub32;
    logic [31:0] a32, b32, res32;
    logic        busy32, done32, cout32, ovf32, zero32;

    int n_checks = 0;
    int n_fail   = 0;

    seq_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start8[0]), .sub(sub8[0]), .a(a8[0]), .b(b8[0]),
        .busy(busy8[0]), .done(done8[0]), .result(res8[0]), .cout(cout8[0]), .ovf(ovf8[0]),
        .zero(zero8[0])
    );

    seq_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start8[1]), .sub(sub8[1]), .a(a8[1]), .b(b8[1]),
        .busy(busy8[1]), .done(done8[1]), .result(res8[1]), .cout(cout8[1]), .ovf(ovf8[1]),
        .zero(zero8[1])
    );

    seq_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start8[2]), .sub(sub8[2]), .a(a8[2]), .b(b8[2]),
        .busy(busy8[2]), .done(done8[2]), .result(res8[2]), .cout(cout8[2]), .ovf(ovf8[2]),
        .zero(zero8[2])
    );

    seq_add_sub #(.WIDTH(32), .DIGIT(4)) u_w32 (
        .clk(clk), .rst(rst32), .start(start32), .sub(sub32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32), .ovf(ovf32),
        .zero(zero32)
    );

    typedef struct {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    vec_t vecs [9];
    int   explat [3] = '{2, 8, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation on 8-bit DUT k; returns edges to done and cycles busy was seen.
    task automatic run8(input int k, input logic s, input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int bcnt);
        @(negedge clk);
        start8[k] = 1'b1;
        sub8[k]   = s;
        a8[k]     = av;
        b8[k]     = bv;
        @(posedge clk);
        #1;
        start8[k] = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!done8[k] && lat < 40) begin
            if (busy8[k]) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 8'h34, 8'h12, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h12, 8'h34, 8'hDE, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        rst32 = 1'b1;
        start32 = 1'b0;
        sub32 = 1'b0;
        a32 = '0;
        b32 = '0;
        for (int k = 0; k < 3; k++) begin
            start8[k] = 1'b0;
            sub8[k]   = 1'b0;
            a8[k]     = '0;
            b8[k]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy_%0d", k), busy8[k], 0);
            check($sformatf("rst_done_%0d", k), done8[k], 0);
            check($sformatf("rst_result_%0d", k), res8[k], 0);
            check($sformatf("rst_cout_%0d", k), cout8[k], 0);
            check($sformatf("rst_ovf_%0d", k), ovf8[k], 0);
            check($sformatf("rst_zero_%0d", k), zero8[k], 0);
        end
        check("rst_busy32", busy32, 0);
        check("rst_result32", res32, 0);
        @(negedge clk);
        rst   = 1'b0;
        rst32 = 1'b0;

        fork
            begin : main8
                int lat, bc;
                logic [7:0] held;
                for (int k = 0; k < 3; k++) begin
                    for (int v = 0; v < 9; v++) begin
                        run8(k, vecs[v].s, vecs[v].a, vecs[v].b, lat, bc);
                        check($sformatf("d%0d_v%0d_done", k, v), done8[k], 1);
                        check($sformatf("d%0d_v%0d_result", k, v), res8[k], vecs[v].r);
                        check($sformatf("d%0d_v%0d_cout", k, v), cout8[k], vecs[v].c);
                        check($sformatf("d%0d_v%0d_ovf", k, v), ovf8[k], vecs[v].o);
                        check($sformatf("d%0d_v%0d_zero", k, v), zero8[k], vecs[v].z);
                        check($sformatf("d%0d_v%0d_latency", k, v), lat, explat[k]);
                        check($sformatf("d%0d_v%0d_busycyc", k, v), bc, explat[k]);
                        @(posedge clk);
                        #1;
                        check($sformatf("d%0d_v%0d_donepulse", k, v), done8[k], 0);
                        check($sformatf("d%0d_v%0d_hold", k, v), res8[k], vecs[v].r);
                    end
                end

                // Inputs change during RUN with start held; second op follows from DONE.
                @(negedge clk);
                start8[0] = 1'b1;
                sub8[0]   = 1'b0;
                a8[0]     = 8'h10;
                b8[0]     = 8'h20;
                @(negedge clk);
                a8[0] = 8'h11;
                b8[0] = 8'h22;
                @(posedge clk);
                #1;
                check("b2b_busy_run", busy8[0], 1);
                @(posedge clk);
                #1;
                check("b2b_first_done", done8[0], 1);
                check("b2b_first_result", res8[0], 8'h30);
                @(posedge clk);
                #1;
                check("b2b_no_idle_busy", busy8[0], 1);
                check("b2b_no_idle_done", done8[0], 0);
                start8[0] = 1'b0;
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                check("b2b_second_done", done8[0], 1);
                check("b2b_second_result", res8[0], 8'h33);

                // Reset on the first RUN edge aborts without a done pulse.
                @(negedge clk);
                start8[0] = 1'b1;
                a8[0]     = 8'h55;
                b8[0]     = 8'h0F;
                @(posedge clk);
                #1;
                check("abort_busy_before", busy8[0], 1);
                @(negedge clk);
                start8[0] = 1'b0;
                rst       = 1'b1;
                @(posedge clk);
                #1;
                check("abort_state", u_d4.state_q, StIdle);
                check("abort_busy", busy8[0], 0);
                check("abort_done", done8[0], 0);
                check("abort_result", res8[0], 0);
                check("abort_cout", cout8[0], 0);
                check("abort_ovf", ovf8[0], 0);
                check("abort_zero", zero8[0], 0);
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("abort_no_done_%0d", i), done8[0], 0);
                end
                run8(0, 1'b1, 8'h80, 8'h01, lat, bc);
                check("post_abort_done", done8[0], 1);
                check("post_abort_result", res8[0], 8'h7F);
                check("post_abort_ovf", ovf8[0], 1);
                check("post_abort_cout", cout8[0], 1);
                check("post_abort_latency", lat, 2);
            end

            begin : rand32
                logic [31:0] ra, rb, bb, er;
                logic        rs;
                logic [32:0] full;
                int          w;
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                @(negedge clk);
                start32 = 1'b1;
                sub32   = rs;
                a32     = ra;
                b32     = rb;
                @(posedge clk);
                #1;
                for (int i = 0; i < 10000; i++) begin
                    w = 0;
                    while (!done32 && w < 20) begin
                        @(posedge clk);
                        #1;
                        w++;
                    end
                    bb   = rs ? ~rb : rb;
                    full = {1'b0, ra} + {1'b0, bb} + {32'd0, rs};
                    er   = full[31:0];
                    check($sformatf("r32_%0d_done", i), done32, 1);
                    check($sformatf("r32_%0d_result", i), res32, er);
                    check($sformatf("r32_%0d_cout", i), cout32, full[32]);
                    check($sformatf("r32_%0d_ovf", i), ovf32,
                          (ra[31] == bb[31]) && (er[31] != ra[31]));
                    check($sformatf("r32_%0d_zero", i), zero32, er == 32'd0);
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    if (i % 97 == 0) rb = ra;
                    start32 = (i < 9999);
                    sub32   = rs;
                    a32     = ra;
                    b32     = rb;
                    @(posedge clk);
                    #1;
                end
                start32 = 1'b0;
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
